bloom_filter_mh: RTL

Multi-hash, parametrised Bloom filter for the packet-classification path. Supports query, insert and clear operations on a word-organised bit array, using NUM_HASH seeded Jenkins one-at-a-time hashes over an arbitrary-width key. Valid/ready handshakes on both sides. Sits between header extraction and the PRT: forwards key+tag with a safe verdict.

---
 rtl/bloom_filter_mh_pkg.sv | 48 ++++
 rtl/bloom_filter_mh_if.sv | 37 +++
 rtl/bloom_filter_mh_bit_ram.sv | 27 ++
 rtl/bloom_filter_mh.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bloom_filter_mh_pkg.sv
// Shared types, hash seeds and the Jenkins one-at-a-time hash for the Bloom filter.
// Latency: none (types and pure combinational function).
// Backpressure: not applicable.
package bloom_filter_mh_pkg;

    // Largest key the hash function accepts; narrower keys are zero-extended.
    localparam int KEY_MAX = 256;

    typedef enum logic [1:0] {
        QUERY  = 2'd0,
        INSERT = 2'd1,
        CLEAR  = 2'd2
    } op_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HASH = 3'd1,
        RD   = 3'd2,
        CHK  = 3'd3,
        RESP = 3'd4,
        CLR  = 3'd5
    } state_t;

    localparam logic [31:0] SEED [8] = '{
        32'h9E37_79B9, 32'h85EB_CA6B, 32'hC2B2_AE35, 32'h27D4_EB2F,
        32'h1656_67B1, 32'hD3A2_646C, 32'hFD70_46C5, 32'hB55A_4F09
    };

    // Bytes are consumed LSB byte first; only the first nbytes take part.
    function automatic logic [31:0] jenkins_oaat(input logic [KEY_MAX-1:0] key,
                                                 input int nbytes,
                                                 input logic [31:0] seed);
        logic [31:0] h;
        h = seed;
        for (int b = 0; b < KEY_MAX / 8; b++) begin
            if (b < nbytes) begin
                h = h + {24'h0, key[b*8 +: 8]};
                h = h + (h << 10);
                h = h ^ (h >> 6);
            end
        end
        h = h + (h << 3);
        h = h ^ (h >> 11);
        h = h + (h << 15);
        return h;
    endfunction

endpackage

// File: rtl/bloom_filter_mh_if.sv
// Request/response bus of the Bloom filter, including status and statistics.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on requests, out_valid/out_ready on results.
interface bloom_filter_mh_if #(
    parameter int KEY_WIDTH = 64,
    parameter int TAG_WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [KEY_WIDTH-1:0] in_key;
    logic [TAG_WIDTH-1:0] in_tag;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_safe;
    logic [1:0]           out_op;
    logic [KEY_WIDTH-1:0] out_key;
    logic [TAG_WIDTH-1:0] out_tag;
    logic                 busy;
    logic [31:0]          stat_queries;
    logic [31:0]          stat_hits;
    logic [31:0]          stat_inserts;

    // The filter itself.
    modport slave (
        input  in_valid, in_op, in_key, in_tag, out_ready,
        output in_ready, out_valid, out_safe, out_op, out_key, out_tag,
               busy, stat_queries, stat_hits, stat_inserts
    );

    // Whoever issues requests and consumes results.
    modport master (
        output in_valid, in_op, in_key, in_tag, out_ready,
        input  in_ready, out_valid, out_safe, out_op, out_key, out_tag,
               busy, stat_queries, stat_hits, stat_inserts
    );
endinterface

// File: rtl/bloom_filter_mh_bit_ram.sv
// Single-port word memory holding the filter bit array; contents are not reset.
// Latency: read data registered one cycle after the address; write on the clock edge.
// Backpressure: none; one access per cycle.
// Ports: clk, i_we (write enable), i_addr (word address), i_wdat (write word), o_rdat (read word).
module bloom_filter_mh_bit_ram #(
    parameter  int DEPTH      = 32,
    parameter  int WORD_WIDTH = 32,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [AW-1:0]         i_addr,
    input  logic [WORD_WIDTH-1:0] i_wdat,
    output logic [WORD_WIDTH-1:0] o_rdat
);
    logic [WORD_WIDTH-1:0] r_mem [DEPTH];
    logic [WORD_WIDTH-1:0] r_rdat;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdat;
        end
        r_rdat <= r_mem[i_addr];
    end

    assign o_rdat = r_rdat;
endmodule

// File: rtl/bloom_filter_mh.sv
// Multi-hash Bloom filter: QUERY / INSERT / CLEAR on a word-organised bit array.
// Latency: QUERY hit / INSERT 2+2*NUM_HASH, QUERY miss on hash j 2+2*(j+1), CLEAR DEPTH+2 cycles.
// Backpressure: one request in flight; in_ready only in IDLE, result held until out_ready.
// Ports: clk, rst (async, active-high), bus (bloom_filter_mh_if.slave: request, result, busy, stats).
// Optional: BLOOM_STATS_EN adds saturating query/hit/insert counters; otherwise stat_* read 0.
module bloom_filter_mh
    import bloom_filter_mh_pkg::*;
#(
    parameter int BIT_ARRAY_SIZE = 1024,
    parameter int WORD_WIDTH     = 32,
    parameter int NUM_HASH       = 3,
    parameter int KEY_WIDTH      = 64,
    parameter int TAG_WIDTH      = 16,
    parameter int HASH_WIDTH     = $clog2(BIT_ARRAY_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    bloom_filter_mh_if.slave  bus
);
    localparam int DEPTH = BIT_ARRAY_SIZE / WORD_WIDTH;
    localparam int AW    = $clog2(DEPTH);
    localparam int BW    = $clog2(WORD_WIDTH);

    state_t                r_state;
    logic                  r_init;        // power-on / reset sweep still pending
    logic [1:0]            r_op;
    logic [KEY_WIDTH-1:0]  r_key;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [HASH_WIDTH-1:0] r_idx [8];
    logic [2:0]            r_k;
    logic                  r_safe;
    logic [AW:0]           r_clr_addr;    // MSB set = sweep finished
    logic                  r_out_valid;
    logic                  r_out_safe;
    logic [1:0]            r_out_op;
    logic [KEY_WIDTH-1:0]  r_out_key;
    logic [TAG_WIDTH-1:0]  r_out_tag;

    logic [HASH_WIDTH-1:0] w_cur_idx;
    logic [AW-1:0]         w_word_addr;
    logic [BW-1:0]         w_bit;
    logic [WORD_WIDTH-1:0] w_rd_word;
    logic                  w_bit_set;
    logic                  w_is_insert;
    logic                  w_safe_nxt;
    logic                  w_chk_done;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_ram_we;
    logic [AW-1:0]         w_ram_addr;
    logic [WORD_WIDTH-1:0] w_ram_wdat;

    assign w_cur_idx   = r_idx[r_k];
    assign w_word_addr = w_cur_idx[HASH_WIDTH-1:BW];
    assign w_bit       = w_cur_idx[BW-1:0];
    assign w_bit_set   = w_rd_word[w_bit];
    assign w_is_insert = (r_op == INSERT);
    assign w_safe_nxt  = r_safe & w_bit_set;
    // A query stops at the first clear bit; an insert must visit every hash.
    assign w_chk_done  = (r_k == 3'(NUM_HASH - 1)) || (!w_is_insert && !w_bit_set);

    assign w_in_fire  = bus.in_valid && bus.in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;

    assign w_ram_we   = ((r_state == CLR) && !r_clr_addr[AW]) || ((r_state == CHK) && w_is_insert);
    assign w_ram_addr = (r_state == CLR) ? r_clr_addr[AW-1:0] : w_word_addr;
    assign w_ram_wdat = (r_state == CLR) ? '0 : (w_rd_word | (WORD_WIDTH'(1) << w_bit));

    bloom_filter_mh_bit_ram #(
        .DEPTH      (DEPTH),
        .WORD_WIDTH (WORD_WIDTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_ram_we),
        .i_addr (w_ram_addr),
        .i_wdat (w_ram_wdat),
        .o_rdat (w_rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_init      <= 1'b1;
            r_op        <= '0;
            r_key       <= '0;
            r_tag       <= '0;
            for (int i = 0; i < 8; i++) r_idx[i] <= '0;
            r_k         <= '0;
            r_safe      <= 1'b0;
            r_clr_addr  <= '0;
            r_out_valid <= 1'b0;
            r_out_safe  <= 1'b0;
            r_out_op    <= '0;
            r_out_key   <= '0;
            r_out_tag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_init) begin
                        r_clr_addr <= '0;
                        r_state    <= CLR;
                    end else if (w_in_fire) begin
                        r_op       <= bus.in_op;
                        r_key      <= bus.in_key;
                        r_tag      <= bus.in_tag;
                        r_k        <= '0;
                        r_safe     <= 1'b1;
                        r_clr_addr <= '0;
                        r_state    <= (bus.in_op == CLEAR) ? CLR : HASH;
                    end
                end
                HASH: begin
                    for (int i = 0; i < 8; i++) begin
                        r_idx[i] <= (i < NUM_HASH)
                            ? HASH_WIDTH'(jenkins_oaat(KEY_MAX'(r_key), KEY_WIDTH / 8, SEED[i]))
                            : '0;
                    end
                    r_state <= RD;
                end
                RD: r_state <= CHK;
                CHK: begin
                    if (w_chk_done) begin
                        r_out_valid <= 1'b1;
                        r_out_safe  <= w_safe_nxt;
                        r_out_op    <= r_op;
                        r_out_key   <= r_key;
                        r_out_tag   <= r_tag;
                        r_state     <= RESP;
                    end else begin
                        r_safe  <= w_safe_nxt;
                        r_k     <= r_k + 3'd1;
                        r_state <= RD;
                    end
                end
                CLR: begin
                    // One extra cycle after the last word write before leaving.
                    if (r_clr_addr[AW]) begin
                        if (r_init) begin
                            r_init  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_safe  <= 1'b0;
                            r_out_op    <= r_op;
                            r_out_key   <= r_key;
                            r_out_tag   <= r_tag;
                            r_state     <= RESP;
                        end
                    end else begin
                        r_clr_addr <= r_clr_addr + (AW+1)'(1);
                    end
                end
                RESP: begin
                    if (w_out_fire) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE) && !r_init;
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.out_safe  = r_out_safe;
    assign bus.out_op    = r_out_op;
    assign bus.out_key   = r_out_key;
    assign bus.out_tag   = r_out_tag;

`ifdef BLOOM_STATS_EN
    logic [31:0] r_stat_queries;
    logic [31:0] r_stat_hits;
    logic [31:0] r_stat_inserts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_queries <= '0;
            r_stat_hits    <= '0;
            r_stat_inserts <= '0;
        end else if (w_in_fire && (bus.in_op == CLEAR)) begin
            r_stat_queries <= '0;
            r_stat_hits    <= '0;
            r_stat_inserts <= '0;
        end else if (w_out_fire) begin
            // Reserved op code 3 counts as a query.
            if (r_out_op == INSERT) begin
                if (r_stat_inserts != '1) r_stat_inserts <= r_stat_inserts + 32'd1;
            end else if (r_out_op != CLEAR) begin
                if (r_stat_queries != '1) r_stat_queries <= r_stat_queries + 32'd1;
                if (r_out_safe && (r_stat_hits != '1)) r_stat_hits <= r_stat_hits + 32'd1;
            end
        end
    end

    assign bus.stat_queries = r_stat_queries;
    assign bus.stat_hits    = r_stat_hits;
    assign bus.stat_inserts = r_stat_inserts;
`else
    assign bus.stat_queries = '0;
    assign bus.stat_hits    = '0;
    assign bus.stat_inserts = '0;
`endif
endmodule
